// File: rtl/zx_video_pkg.sv
// Shared types and helpers for the ZX81 video output stage.
package zx_video_pkg;

   localparam int LINE_CNT_W = 10;

   // odd marks a pixel that should be dimmed: scanlines enabled and an odd line
   typedef struct packed {
      logic pix;
      logic hs;
      logic vs;
      logic de;
      logic odd;
   } pix_tuple_t;

   function automatic logic [15:0] dim_half(input logic [15:0] c);
      return c >> 1;
   endfunction

endpackage

// File: rtl/zx_video_delay.sv
// Enable-gated shift register; DEPTH enables from din to dout, holds while en is low.
module zx_video_delay #(
   parameter int WIDTH = 5,
   parameter int DEPTH = 2
) (
   input  logic             clk_sys,
   input  logic             reset,
   input  logic             en,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [DEPTH-1:0][WIDTH-1:0] stage_q;
   logic [DEPTH-1:0][WIDTH-1:0] stage_d;

   always_comb begin
      stage_d = stage_q;
      if (en) begin
         stage_d[0] = din;
         for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
         end
      end
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         stage_q <= '0;
      end else begin
         stage_q <= stage_d;
      end
   end

   assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/zx_video_out.sv
// ZX81 1-bit video to N-bit RGB with sync polarity; PIPE_STAGES pixel enables of latency.
// Optional odd-line dimming is built only when ZX_VIDEO_SCANLINES_EN is defined.
module zx_video_out
   import zx_video_pkg::*;
#(
   parameter int                        COLOR_BITS     = 4,
   parameter int                        PIPE_STAGES    = 2,
   parameter logic [3*COLOR_BITS-1:0]   FG_COLOR       = '1,
   parameter logic [3*COLOR_BITS-1:0]   BG_COLOR       = '0,
   parameter bit                        HS_ACTIVE_HIGH = 1'b0,
   parameter bit                        VS_ACTIVE_HIGH = 1'b0
) (
   input  logic                  clk_sys,
   input  logic                  reset,
   input  logic                  ce_pix,
   input  logic                  video,
   input  logic                  hsync_in,
   input  logic                  vsync_in,
   input  logic                  vde_in,
   input  logic                  invert,
   input  logic                  scanlines,
   output logic [COLOR_BITS-1:0] red,
   output logic [COLOR_BITS-1:0] green,
   output logic [COLOR_BITS-1:0] blue,
   output logic                  hsync,
   output logic                  vsync,
   output logic                  vde
);

   localparam int RGB_W = 3 * COLOR_BITS;

   pix_tuple_t tuple_in;
   pix_tuple_t tuple_out;
   logic       odd_line;

`ifdef ZX_VIDEO_SCANLINES_EN
   logic [LINE_CNT_W-1:0] line_q, line_d;
   logic                  hs_prev_q, hs_prev_d;
   logic                  vs_prev_q, vs_prev_d;

   // Vsync clear takes priority over an hsync increment on the same enable
   always_comb begin
      line_d    = line_q;
      hs_prev_d = hs_prev_q;
      vs_prev_d = vs_prev_q;
      if (ce_pix) begin
         hs_prev_d = hsync_in;
         vs_prev_d = vsync_in;
         if (vsync_in && !vs_prev_q) begin
            line_d = '0;
         end else if (hsync_in && !hs_prev_q && (line_q != {LINE_CNT_W{1'b1}})) begin
            line_d = line_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         line_q    <= '0;
         hs_prev_q <= 1'b0;
         vs_prev_q <= 1'b0;
      end else begin
         line_q    <= line_d;
         hs_prev_q <= hs_prev_d;
         vs_prev_q <= vs_prev_d;
      end
   end

   assign odd_line = scanlines & line_d[0];
`else
   logic unused_scan;
   assign odd_line    = 1'b0;
   assign unused_scan = ^{scanlines, tuple_out.odd};
`endif

   always_comb begin
      tuple_in     = '0;
      tuple_in.pix = video ^ invert;
      tuple_in.hs  = hsync_in;
      tuple_in.vs  = vsync_in;
      tuple_in.de  = vde_in;
      tuple_in.odd = odd_line;
   end

   zx_video_delay #(
      .WIDTH ($bits(pix_tuple_t)),
      .DEPTH (PIPE_STAGES)
   ) u_delay (
      .clk_sys (clk_sys),
      .reset   (reset),
      .en      (ce_pix),
      .din     (tuple_in),
      .dout    (tuple_out)
   );

   // Decode straight from the last pipeline flop so every output shares one latency
   logic [RGB_W-1:0] rgb_sel;

   always_comb begin
      rgb_sel = '0;
      if (tuple_out.de) begin
         rgb_sel = tuple_out.pix ? FG_COLOR : BG_COLOR;
      end
      red   = rgb_sel[RGB_W-1 -: COLOR_BITS];
      green = rgb_sel[2*COLOR_BITS-1 -: COLOR_BITS];
      blue  = rgb_sel[COLOR_BITS-1:0];
`ifdef ZX_VIDEO_SCANLINES_EN
      if (tuple_out.odd) begin
         red   = COLOR_BITS'(dim_half(16'(red)));
         green = COLOR_BITS'(dim_half(16'(green)));
         blue  = COLOR_BITS'(dim_half(16'(blue)));
      end
`endif
   end

   assign hsync = tuple_out.hs ^ !HS_ACTIVE_HIGH;
   assign vsync = tuple_out.vs ^ !VS_ACTIVE_HIGH;
   assign vde   = tuple_out.de;

endmodule

// File: tb/tb_zx_video_out.sv
// Directed bench for zx_video_out: default-polarity and active-high-sync instances share stimulus.
module tb_zx_video_out;

   logic clk_sys = 1'b0;
   always #5 clk_sys = ~clk_sys;

   logic reset, ce_pix, video, hsync_in, vsync_in, vde_in, invert, scanlines;
   logic [3:0] red, green, blue, red_h, green_h, blue_h;
   logic hsync, vsync, vde, hsync_h, vsync_h, vde_h;

   zx_video_out u_dut (
      .clk_sys(clk_sys), .reset(reset), .ce_pix(ce_pix), .video(video),
      .hsync_in(hsync_in), .vsync_in(vsync_in), .vde_in(vde_in), .invert(invert),
      .scanlines(scanlines), .red(red), .green(green), .blue(blue),
      .hsync(hsync), .vsync(vsync), .vde(vde)
   );

   zx_video_out #(.HS_ACTIVE_HIGH(1'b1), .VS_ACTIVE_HIGH(1'b1)) u_dut_hi (
      .clk_sys(clk_sys), .reset(reset), .ce_pix(ce_pix), .video(video),
      .hsync_in(hsync_in), .vsync_in(vsync_in), .vde_in(vde_in), .invert(invert),
      .scanlines(scanlines), .red(red_h), .green(green_h), .blue(blue_h),
      .hsync(hsync_h), .vsync(vsync_h), .vde(vde_h)
   );

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk_sys);
      #1;
   endtask

   typedef struct {
      logic        video, inv, hs, vs, de;
      logic [11:0] rgb;
      logic        hs_lo, hs_hi, vs_lo, de_o;
   } vec_t;

   vec_t tbl[10];

   initial begin
      tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 12'hFFF, 1'b1, 1'b0, 1'b1, 1'b1};
      tbl[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 12'h000, 1'b1, 1'b0, 1'b1, 1'b1};
      tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 12'hFFF, 1'b1, 1'b0, 1'b1, 1'b1};
      tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 12'h000, 1'b1, 1'b0, 1'b1, 1'b1};
      tbl[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 1'b1, 1'b0};
      tbl[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 1'b1, 1'b0};
      tbl[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 12'hFFF, 1'b0, 1'b1, 1'b1, 1'b1};
      tbl[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 12'h000, 1'b1, 1'b0, 1'b0, 1'b1};
      tbl[8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 12'h000, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[9] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 12'hFFF, 1'b1, 1'b0, 1'b1, 1'b1};

      reset = 1'b1; ce_pix = 1'b1; video = 1'b1; vde_in = 1'b1;
      hsync_in = 1'b0; vsync_in = 1'b0; invert = 1'b0; scanlines = 1'b0;

      // Reset held for two cycles with a lit, visible pixel at the input
      for (int i = 0; i < 2; i++) begin
         step();
         check("rst_rgb", {red, green, blue}, 12'h000);
         check("rst_vde", vde, 1'b0);
         check("rst_hs", hsync, 1'b1);
         check("rst_vs", vsync, 1'b1);
         check("rst_hs_hi", hsync_h, 1'b0);
      end
      reset = 1'b0;
      check("rel0_rgb", {red, green, blue}, 12'h000);
      step();
      check("rel1_rgb", {red, green, blue}, 12'h000);
      check("rel1_vde", vde, 1'b0);
      step();
      check("rel2_rgb", {red, green, blue}, 12'hFFF);
      check("rel2_vde", vde, 1'b1);

      // Reset acts even while the pixel enable is low
      ce_pix = 1'b0; reset = 1'b1;
      step();
      check("rst_noce_rgb", {red, green, blue}, 12'h000);
      check("rst_noce_vde", vde, 1'b0);
      reset = 1'b0; ce_pix = 1'b1;

      // Table: sample before driving, expecting the vector from two enables back
      for (int s = 0; s < 12; s++) begin
         step();
         if (s >= 2) begin
            check("tbl_rgb", {red, green, blue}, tbl[s-2].rgb);
            check("tbl_hs", hsync, tbl[s-2].hs_lo);
            check("tbl_hs_hi", hsync_h, tbl[s-2].hs_hi);
            check("tbl_vs", vsync, tbl[s-2].vs_lo);
            check("tbl_vs_hi", vsync_h, !tbl[s-2].vs_lo);
            check("tbl_vde", vde, tbl[s-2].de_o);
         end
         if (s < 10) begin
            video = tbl[s].video; invert = tbl[s].inv; hsync_in = tbl[s].hs;
            vsync_in = tbl[s].vs; vde_in = tbl[s].de;
         end else begin
            video = 1'b0; invert = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0; vde_in = 1'b1;
         end
      end

      // Enable every 4th cycle; one-enable pulse shows for 4 cycles, 2 enables later
      for (int t = 0; t < 24; t++) begin
         step();
         check("ce_rgb", {red, green, blue}, (t >= 9 && t <= 12) ? 12'hFFF : 12'h000);
         ce_pix = (t % 4 == 0);
         video  = (t == 4);
      end

      // 12-enable hsync pulse with vde_in driven as its complement
      ce_pix = 1'b1; video = 1'b0;
      for (int t = 0; t < 20; t++) begin
         step();
         check("pulse_hs", hsync, !(t >= 4 && t < 16));
         check("pulse_hs_hi", hsync_h, (t >= 4 && t < 16));
         check("pulse_vde", vde, !(t >= 4 && t < 16));
         hsync_in = (t >= 2 && t < 14);
         vde_in   = !hsync_in;
      end
      hsync_in = 1'b0; vde_in = 1'b1;

`ifdef ZX_VIDEO_SCANLINES_EN
      reset = 1'b1; step(); reset = 1'b0;
      scanlines = 1'b1; video = 1'b0; vde_in = 1'b1;
      vsync_in = 1'b1; step(); vsync_in = 1'b0; step();
      hsync_in = 1'b1; step(); hsync_in = 1'b0; video = 1'b1;
      step(); step(); step();
      check("scan_odd_rgb", {red, green, blue}, 12'h777);
      hsync_in = 1'b1; step(); hsync_in = 1'b0;
      step(); step(); step();
      check("scan_even_rgb", {red, green, blue}, 12'hFFF);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/zx_video_out.md
# zx_video_out

Parametrised video output stage for the ZX81 core. It turns the core's 1-bit video, hsync, vsync and vde into N-bit RGB with programmable foreground/background colours, inverse video, selectable sync polarity and an optional scanline-dimming effect. All signals pass through a matched, clock-enabled pipeline so pixels and syncs leave aligned. It sits between `fpga_zx81` and the board's VGA pins and replaces the fixed `{4{video}}` replication.

## Interface
Parameters:
- `COLOR_BITS`, 4: width of each of red/green/blue.
- `PIPE_STAGES`, 2: pipeline depth from input to output, in pixel enables; legal range 1..8.
- `FG_COLOR`, all ones (3*COLOR_BITS): {r,g,b} shown for video=1.
- `BG_COLOR`, 0 (3*COLOR_BITS): {r,g,b} shown for video=0.
- `HS_ACTIVE_HIGH`, 0: output hsync polarity; 0 = active-low.
- `VS_ACTIVE_HIGH`, 0: output vsync polarity; 0 = active-low.

Ports:
- `clk_sys` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `ce_pix` in 1: pixel clock enable; the pipeline advances only when it is high.
- `video` in 1: core pixel, 1 = lit.
- `hsync_in` in 1: core hsync, active-high.
- `vsync_in` in 1: core vsync, active-high.
- `vde_in` in 1: display enable, 1 = visible.
- `invert` in 1: swaps FG and BG; sampled with the pixel.
- `scanlines` in 1: enables odd-line dimming; ignored unless built with the scanline feature.
- `red`, `green`, `blue` out COLOR_BITS each: colour.
- `hsync` out 1: polarity-adjusted hsync.
- `vsync` out 1: polarity-adjusted vsync.
- `vde` out 1: delayed display enable.

## Operation
- Stage 0: on `ce_pix`, register the input tuple {video^invert, hsync_in, vsync_in, vde_in}.
- Stages 1..PIPE_STAGES-1: a shift register of that tuple, advanced only on `ce_pix`. When `ce_pix` is low, everything holds.
- Colour select: pixel=1 gives FG_COLOR, pixel=0 gives BG_COLOR.
- Blanking: delayed vde=0 forces RGB to 0 regardless of pixel or invert.
- Sync outputs are the delayed active-high syncs XOR the inverse of the polarity parameter. Their inactive level is therefore 1 for active-low and 0 for active-high.
- Line counter, 10 bits:
  - Increments on each rising edge of `hsync_in` seen at stage 0 (previous value 0, current value 1, on `ce_pix`).
  - Clears to 0 on a rising edge of `vsync_in`. If both edges occur on the same enable, the clear wins.
  - Saturates at 1023; no wrap.
- Line parity is carried through the pipeline alongside the tuple, so dimming aligns with its pixels.

## Timing
- Latency: exactly PIPE_STAGES `ce_pix` pulses from input to every output. RGB, sync and vde latencies are identical.
- Outputs are registered; there is no combinational path from inputs to outputs.
- Reset, taking effect at the next `clk_sys` edge regardless of `ce_pix`:
  - Pipeline tuples become 0, with vde=0.
  - RGB = 0, vde = 0.
  - hsync/vsync at their inactive level.
  - Line counter = 0.
- Reset asserted mid-line behaves the same way. After release, the first valid output appears PIPE_STAGES enables later.
- `invert` changes affect only pixels sampled on or after the change; pixels already in the pipeline are unaffected.

## Configuration
- Macro `ZX_VIDEO_SCANLINES_EN`.
  - Defined: when `scanlines`=1 and the pixel's line is odd, each RGB component is shifted right by 1 (floor), applied after blanking.
  - Undefined: the line counter and parity logic are not built, the `scanlines` port is ignored, and output colour equals the selected FG/BG exactly.

## Structure
- Shared package `zx_video_pkg`: pipeline tuple struct {pix, hs, vs, de, odd}, `LINE_CNT_W`=10, and a `dim_half` function.
- One sub-module, `zx_video_delay`: a parametrised enable-gated shift register (WIDTH, DEPTH) used for the tuple pipeline.

## Test plan
- Reset: assert `reset` for 2 cycles with video=1 and vde_in=1. Required response: RGB=0, vde=0, hsync=1 and vsync=1 (defaults) while reset is held, and for the following PIPE_STAGES enables.
- Latency and colour: with `ce_pix` tied to 1, defaults, vde_in=1 and video=1 at cycle N, red/green/blue=4'hF at cycle N+2. With video=0 they are 0.
- Invert and blank: with invert=1 and video=0, RGB=F; with vde_in=0, RGB=0 whatever invert and video are.
- Clock enable: set `ce_pix` high every 4th cycle and drive a single-enable video pulse. The output pulse lasts 4 cycles and appears 2 enables later.
- Sync polarity:
  - With HS_ACTIVE_HIGH=1, an hsync_in pulse of 12 enables gives hsync high for 12 enables, aligned with vde.
  - With the default, hsync goes low for those 12 enables.
- Scanlines (macro defined, scanlines=1):
  - After a vsync rise and 1 hsync rise, the line is odd and a lit pixel gives RGB=4'h7.
  - After 2 hsync rises, the same pixel gives RGB=4'hF.
